rf_param: RTL

Parametrised register file with two addressed read ports, a dedicated accumulator read port and one write port. Adds an asynchronous zeroing reset, a hardware clear sequencer that sweeps every entry to zero one per cycle, out-of-range address protection and an optional same-cycle write-to-read bypass. It sits between instruction decode (pointers) and the ALU (operands), with the accumulator continuously visible.

---
 rtl/rf_param.sv | 107 ++++++++++
 1 files changed

// File: rtl/rf_param.sv
// Parametrised register file: two addressed read ports, a fixed accumulator port,
// one write port and a hardware clear sweep. Define RF_BYPASS_EN for write-to-read bypass.
module rf_param #(
    parameter  int W       = 8,
    parameter  int DEPTH   = 16,
    parameter  int ACC_IDX = DEPTH - 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] ptr_w,
    input  logic [W-1:0]  di,
    input  logic [AW-1:0] ptr_a,
    input  logic [AW-1:0] ptr_b,
    input  logic          clr_req,
    output logic [W-1:0]  do_a,
    output logic [W-1:0]  do_b,
    output logic [W-1:0]  do_acc,
    output logic          busy,
    output logic          clr_done
);

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ACC_PTR   = AW'(ACC_IDX);

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  core_q [DEPTH];
    logic [W-1:0]  core_d [DEPTH];
    logic          wr_ok;
    logic [AW-1:0] rd_ptr  [3];
    logic [W-1:0]  rd_data [3];

    // Out-of-range write pointers only exist when DEPTH is not a power of two.
    assign wr_ok = we && (state_q != SWEEP) && ({1'b0, ptr_w} < DEPTH_EXT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            SWEEP: begin
                if (cnt_q == LAST_IDX) state_d = DONE;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q == SWEEP);
        clr_done = (state_q == DONE);
    end

    // A sweep and an accepted write never coincide, so the order below is free.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) core_d[i] = core_q[i];
        if (state_q == SWEEP) core_d[cnt_q] = '0;
        if (wr_ok)            core_d[ptr_w] = di;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) core_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) core_q[i] <= core_d[i];
        end
    end

    always_comb begin
        rd_ptr[0] = ptr_a;
        rd_ptr[1] = ptr_b;
        rd_ptr[2] = ACC_PTR;
        for (int i = 0; i < 3; i++) begin
            rd_data[i] = '0;
            if ({1'b0, rd_ptr[i]} < DEPTH_EXT) rd_data[i] = core_q[rd_ptr[i]];
`ifdef RF_BYPASS_EN
            if (wr_ok && (rd_ptr[i] == ptr_w)) rd_data[i] = di;
`endif
        end
    end

    assign do_a   = rd_data[0];
    assign do_b   = rd_data[1];
    assign do_acc = rd_data[2];

endmodule
